// File: rtl/barrel_shifter.sv
// -----------------------------------------------------------------------------
// barrel_shifter
//
// Combinational barrel shifter/rotator followed by a single output register.
// A SIZE-bit word is shifted or rotated left or right by 0..SIZE-1 positions,
// with exactly one clock cycle of latency and a new operation every cycle.
//
// Both directions share one right-moving chain of log2(SIZE) mux stages.
// Left operations bit-reverse the word on the way in and on the way out,
// so a right move on the reversed word is a left move on the original.
//
// Optional feature (compile-time macro ARITH_SHIFT_EN):
//   defined   - a right logical shift (sr=0, direction=1) becomes arithmetic,
//               filling vacated MSBs with input[SIZE-1].
//   undefined - right shifts always zero-fill.
//   The port list is identical in both builds.
//
// Parameters:
//   SIZE  data width in bits, power of two, >= 2 (default 4)
//   SHW   derived shift-amount width, $clog2(SIZE); not overridable
//
// Ports:
//   clk                           rising-edge clock
//   rst_n                         asynchronous active-low reset
//   barrelShifter_port_input      [SIZE-1:0] data word
//   barrelShifter_port_sr         0 = logical shift, 1 = rotate
//   barrelShifter_port_shift      [SHW-1:0]  unsigned amount
//   barrelShifter_port_direction  0 = left (toward MSB), 1 = right (toward LSB)
//   barrelShifter_port_output     [SIZE-1:0] registered result
// -----------------------------------------------------------------------------
module barrel_shifter #(
  parameter  int SIZE = 4,
  localparam int SHW  = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] barrelShifter_port_input,
  input  logic            barrelShifter_port_sr,
  input  logic [SHW-1:0]  barrelShifter_port_shift,
  input  logic            barrelShifter_port_direction,
  output logic [SIZE-1:0] barrelShifter_port_output
);

  function automatic logic [SIZE-1:0] bit_reverse(input logic [SIZE-1:0] word);
    logic [SIZE-1:0] rev;
    rev = '0;
    for (int i = 0; i < SIZE; i++) begin
      rev[i] = word[SIZE-1-i];
    end
    return rev;
  endfunction

  // Value shifted into vacated positions during a non-rotating move.
  // On the left path this is always 0, since the left path never sets it.
  logic fill;
`ifdef ARITH_SHIFT_EN
  assign fill = ~barrelShifter_port_sr & barrelShifter_port_direction
              & barrelShifter_port_input[SIZE-1];
`else
  assign fill = 1'b0;
`endif

  // stage[k] is the word entering mux stage k; stage[SHW] is the final word.
  logic [SIZE-1:0] stage [SHW+1];
  logic [SIZE-1:0] result;

  assign stage[0] = barrelShifter_port_direction ? barrelShifter_port_input
                                                 : bit_reverse(barrelShifter_port_input);

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int STEP = 1 << k;
    logic [SIZE-1:0] moved;

    // Bits within range take their neighbour STEP positions up; bits at the
    // top either wrap around (rotate) or take the fill value (shift).
    for (genvar i = 0; i < SIZE; i++) begin : g_bit
      if (i + STEP < SIZE) begin : g_inside
        assign moved[i] = stage[k][i+STEP];
      end else begin : g_wrap
        assign moved[i] = barrelShifter_port_sr ? stage[k][i+STEP-SIZE] : fill;
      end
    end

    assign stage[k+1] = barrelShifter_port_shift[k] ? moved : stage[k];
  end

  assign result = barrelShifter_port_direction ? stage[SHW] : bit_reverse(stage[SHW]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the asynchronous clear sits in the sensitivity list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      barrelShifter_port_output <= '0;
    end else begin
      barrelShifter_port_output <= result;
    end
  end

endmodule

// File: tb/tb_barrel_shifter.sv
// -----------------------------------------------------------------------------
// tb_barrel_shifter
//
// Self-checking bench for barrel_shifter at SIZE=4: directed table of
// vectors, a hand-written asynchronous reset sequence, an exhaustive sweep and
// random vectors, all compared against an arithmetic reference model.
// Define ARITH_SHIFT_EN for both files to check the arithmetic-right build.
// -----------------------------------------------------------------------------
module tb_barrel_shifter;

  localparam int SIZE = 4;
  localparam int SHW  = $clog2(SIZE);
  localparam int MASK = (1 << SIZE) - 1;

  logic            clk;
  logic            rst_n;
  logic [SIZE-1:0] din;
  logic            sr;
  logic [SHW-1:0]  shift;
  logic            dir;
  logic [SIZE-1:0] dout;

  int vectors;
  int miscompares;

  barrel_shifter #(.SIZE(SIZE)) dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .barrelShifter_port_input     (din),
    .barrelShifter_port_sr        (sr),
    .barrelShifter_port_shift     (shift),
    .barrelShifter_port_direction (dir),
    .barrelShifter_port_output    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [SIZE-1:0] din;
    logic            sr;
    logic [2:0]      amt_raw;   // wider than the port so 4 can be driven
    logic            dir;
    logic [SIZE-1:0] expected;
  } vec_t;

  // Reference: plain integer arithmetic on the rules for each mode.
  function automatic logic [SIZE-1:0] ref_model(input int a, input bit rot,
                                                input int n, input bit right);
    int r;
    if (rot && !right)      r = (a << n) | (a >> (SIZE - n));
    else if (rot && right)  r = (a >> n) | (a << (SIZE - n));
    else if (!right)        r = a << n;
    else begin
      r = a >> n;
`ifdef ARITH_SHIFT_EN
      if (a >= (1 << (SIZE - 1))) r = r | (MASK - (MASK >> n));
`endif
    end
    return SIZE'(r & MASK);
  endfunction

  task automatic check(input string name, input logic [SIZE-1:0] actual,
                       input logic [SIZE-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Drive one operation just after an edge, then check it just after the next.
  task automatic apply(input string name, input logic [SIZE-1:0] a, input logic m,
                       input logic [2:0] amt_raw, input logic d,
                       input logic [SIZE-1:0] expected);
    din   = a;
    sr    = m;
    shift = amt_raw[SHW-1:0];
    dir   = d;
    @(posedge clk);
    #1;
    check(name, dout, expected);
  endtask

  vec_t table_v[$];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    din   = '0;
    sr    = 1'b0;
    shift = '0;
    dir   = 1'b0;

    // Directed vectors, input 1011.
    table_v.push_back('{"shl1",      4'b1011, 1'b0, 3'd1, 1'b0, 4'b0110});
    table_v.push_back('{"rol1",      4'b1011, 1'b1, 3'd1, 1'b0, 4'b0111});
`ifdef ARITH_SHIFT_EN
    table_v.push_back('{"shr1",      4'b1011, 1'b0, 3'd1, 1'b1, 4'b1101});
    table_v.push_back('{"shr3",      4'b1011, 1'b0, 3'd3, 1'b1, 4'b1111});
`else
    table_v.push_back('{"shr1",      4'b1011, 1'b0, 3'd1, 1'b1, 4'b0101});
    table_v.push_back('{"shr3",      4'b1011, 1'b0, 3'd3, 1'b1, 4'b0001});
`endif
    table_v.push_back('{"ror1",      4'b1011, 1'b1, 3'd1, 1'b1, 4'b1101});
    table_v.push_back('{"rol3",      4'b1011, 1'b1, 3'd3, 1'b0, 4'b1101});
    table_v.push_back('{"ror3",      4'b1011, 1'b1, 3'd3, 1'b1, 4'b0111});
    table_v.push_back('{"shl3",      4'b1011, 1'b0, 3'd3, 1'b0, 4'b1000});
    table_v.push_back('{"shl0",      4'b1011, 1'b0, 3'd0, 1'b0, 4'b1011});
    table_v.push_back('{"shr0",      4'b1011, 1'b0, 3'd0, 1'b1, 4'b1011});
    table_v.push_back('{"rol0",      4'b1011, 1'b1, 3'd0, 1'b0, 4'b1011});
    table_v.push_back('{"ror0",      4'b1011, 1'b1, 3'd0, 1'b1, 4'b1011});
    table_v.push_back('{"shl4trunc", 4'b1011, 1'b0, 3'd4, 1'b0, 4'b1011});
    table_v.push_back('{"shr4trunc", 4'b1011, 1'b0, 3'd4, 1'b1, 4'b1011});
    table_v.push_back('{"rol4trunc", 4'b1011, 1'b1, 3'd4, 1'b0, 4'b1011});
    table_v.push_back('{"ror4trunc", 4'b1011, 1'b1, 3'd4, 1'b1, 4'b1011});

    // Output must be 0 while held in reset, even across clock edges.
    @(posedge clk);
    #1;
    check("reset_hold", dout, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < table_v.size(); i++) begin
      apply(table_v[i].name, table_v[i].din, table_v[i].sr, table_v[i].amt_raw,
            table_v[i].dir, table_v[i].expected);
    end

    // Asynchronous reset mid-stream: output 0110 cleared before the next edge.
    apply("pre_reset", 4'b1011, 1'b0, 3'd1, 1'b0, 4'b0110);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", dout, '0);
    @(posedge clk);
    #1;
    check("reset_held_edge", dout, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("after_release_pre_edge", dout, '0);
    @(posedge clk);
    #1;
    check("first_edge_after_release", dout, 4'b0110);

    // Exhaustive sweep, one operation per cycle.
    for (int a = 0; a < (1 << SIZE); a++) begin
      for (int m = 0; m < 2; m++) begin
        for (int n = 0; n < SIZE; n++) begin
          for (int d = 0; d < 2; d++) begin
            apply("sweep", SIZE'(a), m[0], 3'(n), d[0], ref_model(a, m[0], n, d[0]));
          end
        end
      end
    end

    // Random back-to-back operations.
    for (int t = 0; t < 200; t++) begin
      int a, n;
      bit m, d;
      a = int'($urandom_range(MASK, 0));
      n = int'($urandom_range(SIZE - 1, 0));
      m = 1'($urandom);
      d = 1'($urandom);
      apply("random", SIZE'(a), m, 3'(n), d, ref_model(a, m, n, d));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
